// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: push/pop/flush with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fq_entry_t        wr_entry,
  output fq_entry_t        rd_entry,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Guards keep the queue consistent even if the caller misbehaves.
  assign pop_ok  = pop & (count != '0) & ~flush;
  assign push_ok = push & ((count != CNT_W'(DEPTH)) | pop_ok) & ~flush;

  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC register, push/redirect control and the fetch queue.
// Define FETCH_PERF_EN to add saturating perf_fetched/perf_full_stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [XLEN-1:0]           imem_addr,
  input  logic [XLEN-1:0]           imem_instr,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      fq_valid,
  output logic [XLEN-1:0]           fq_pc,
  output logic [XLEN-1:0]           fq_instr,
  input  logic                      fq_ready,
  output logic [$clog2(FQ_DEPTH):0] fq_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_full_stall
`endif
);

  localparam int              CNT_W       = $clog2(FQ_DEPTH) + 1;
  localparam logic [XLEN-1:0] RESET_PC_AL = align_pc(RESET_PC);

  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;
  fq_entry_t        wr_entry;
  fq_entry_t        rd_entry;

  assign full     = (count == CNT_W'(FQ_DEPTH));
  assign fq_valid = (count != '0) & ~redirect_valid;
  assign pop      = fq_valid & fq_ready;
  // A pop frees a slot in the same cycle, so a full queue still streams.
  assign push     = ~redirect_valid & (~full | pop);

  assign imem_addr = pc;
  assign wr_entry  = '{pc: pc, instr: imem_instr};
  assign fq_pc     = rd_entry.pc;
  assign fq_instr  = rd_entry.instr;
  assign fq_count  = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC_AL;
    end else if (redirect_valid) begin
      pc <= align_pc(redirect_pc);
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .count    (count)
  );

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched    <= '0;
      perf_full_stall <= '0;
    end else begin
      if (push)        perf_fetched    <= sat_inc(perf_fetched);
      if (full & ~pop) perf_full_stall <= sat_inc(perf_full_stall);
    end
  end
`endif

endmodule
